prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader.sv | 77 +++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream source and program-memory load bus of the loader.
interface prog_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        LE;
  logic [7:0]  LA;
  logic [11:0] LI;
  logic        cpu_en;
  logic        busy;
  logic        done;
  logic        err;
  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, LE, LA, LI, cpu_en, busy, done, err
  );
  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, LE, LA, LI, cpu_en, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a count-prefixed, XOR-checksummed byte stream into program memory.
module prog_loader (
  input logic        clk,
  input logic        rst,
  prog_loader_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] COUNT = 3'd1;
  localparam logic [2:0] HI    = 3'd2;
  localparam logic [2:0] LO    = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] CHECK = 3'd5;
  logic [2:0] state;
  logic [7:0] addr;
  logic [7:0] chk;
  logic [7:0] held;
  logic [8:0] remaining;
  logic       acc;
  assign bus.byte_ready = state == COUNT || state == HI || state == LO || state == CHECK;
  assign bus.busy       = state != IDLE;
  assign bus.cpu_en     = state == IDLE;
  assign acc            = bus.byte_valid & bus.byte_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      chk       <= '0;
      held      <= '0;
      remaining <= '0;
      bus.LE    <= 1'b0;
      bus.LA    <= '0;
      bus.LI    <= '0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.LE <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
          addr     <= '0;
          chk      <= '0;
          state    <= COUNT;
        end
        // a zero count byte encodes 256 instructions
        COUNT: if (acc) begin
          remaining <= {bus.byte_data == 8'd0, bus.byte_data};
          chk       <= bus.byte_data;
          state     <= HI;
        end
        HI: if (acc) begin
          held  <= bus.byte_data;
          chk   <= chk ^ bus.byte_data;
          state <= LO;
        end
        LO: if (acc) begin
          chk    <= chk ^ bus.byte_data;
          bus.LI <= {held, bus.byte_data[3:0]};
          bus.LA <= addr;
          bus.LE <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          addr      <= addr + 8'd1;
          remaining <= remaining - 9'd1;
          state     <= remaining == 9'd1 ? CHECK : HI;
        end
        CHECK: if (acc) begin
          bus.done <= bus.byte_data == chk;
          bus.err  <= bus.byte_data != chk;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scenario tasks with a write scoreboard checked on every LE pulse.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  logic [19:0] sb[$];
  logic [7:0] his[256];
  logic [7:0] los[256];
  logic le_prev = 1'b0;
  bit gap = 1'b0;

  prog_loader_if bif ();
  prog_loader dut (.clk(clk), .rst(rst), .bus(bif));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (bif.LE) begin
      logic [19:0] e;
      n_total++;
      if (sb.size() == 0) $display("FAIL write_unexpected LA=%h LI=%h required no write", bif.LA, bif.LI);
      else begin
        e = sb.pop_front();
        if ({bif.LA, bif.LI} !== e) $display("FAIL write LA/LI=%h/%h required %h/%h", bif.LA, bif.LI, e[19:12], e[11:0]);
        else n_pass++;
      end
      n_total++;
      if (bif.byte_ready !== 1'b0) $display("FAIL ready_in_write byte_ready=%b required 0", bif.byte_ready);
      else n_pass++;
      n_total++;
      if (le_prev !== 1'b0) $display("FAIL le_width LE high on consecutive cycles required single-cycle pulse");
      else n_pass++;
    end
    le_prev <= bif.LE;
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    bif.byte_valid = 1'b1;
    bif.byte_data  = b;
    @(negedge clk);
    while (bif.byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_total++;
      $display("FAIL send_timeout byte_ready=%b required 1 within 20 cycles", bif.byte_ready);
    end
    @(posedge clk);
    #1;
    bif.byte_valid = 1'b0;
    bif.byte_data  = 8'hxx;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
  endtask

  task automatic do_load(input int n, input bit bad, input bit start_busy);
    logic [7:0] c;
    logic [7:0] chk;
    c = n[7:0];
    pulse_start();
    @(negedge clk);
    n_total++;
    if ({bif.busy, bif.cpu_en, bif.done, bif.err} !== 4'b1000)
      $display("FAIL session_start busy/cpu_en/done/err=%b required 1000", {bif.busy, bif.cpu_en, bif.done, bif.err});
    else n_pass++;
    @(posedge clk);
    #1;
    send(c);
    chk = c;
    if (start_busy) begin
      pulse_start();
      @(negedge clk);
      n_total++;
      if ({bif.busy, bif.byte_ready, bif.LE} !== 3'b110)
        $display("FAIL start_busy busy/ready/LE=%b required 110", {bif.busy, bif.byte_ready, bif.LE});
      else n_pass++;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = i[7:0];
      send(his[i]);
      chk ^= his[i];
      sb.push_back({a, his[i], los[i][3:0]});
      send(los[i]);
      chk ^= los[i];
    end
    send(bad ? chk ^ 8'h01 : chk);
    @(negedge clk);
    n_total++;
    if ({bif.busy, bif.cpu_en, bif.done, bif.err} !== {1'b0, 1'b1, !bad, bad})
      $display("FAIL session_end busy/cpu_en/done/err=%b required %b", {bif.busy, bif.cpu_en, bif.done, bif.err}, {1'b0, 1'b1, !bad, bad});
    else n_pass++;
    n_total++;
    if (sb.size() != 0) $display("FAIL missing_writes pending=%0d required 0", sb.size());
    else n_pass++;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nominal();
    his[0] = 8'hAB; los[0] = 8'hC5;
    his[1] = 8'h12; los[1] = 8'h36;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.start = 1'b1;
    bif.byte_valid = 1'b1;
    bif.byte_data = 8'h05;
    repeat (2) @(posedge clk);
    #1;
    bif.start = 1'b0;
    bif.byte_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bif.LE, bif.LA, bif.LI, bif.byte_ready, bif.busy, bif.cpu_en, bif.done, bif.err} !== {1'b0, 8'h00, 12'h000, 5'b00100})
      $display("FAIL reset_state LE=%b LA=%h LI=%h ready=%b busy=%b cpu_en=%b done=%b err=%b required all 0, cpu_en=1",
               bif.LE, bif.LA, bif.LI, bif.byte_ready, bif.busy, bif.cpu_en, bif.done, bif.err);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (bif.busy !== 1'b0) $display("FAIL idle_hold busy=%b required 0", bif.busy);
    else n_pass++;
  endtask

  task automatic test_nominal();
    set_nominal();
    gap = 1'b0;
    do_load(2, 1'b0, 1'b0);
    n_total++;
    if ({bif.LA, bif.LI} !== {8'h01, 12'h126}) $display("FAIL hold_last LA/LI=%h/%h required 01/126", bif.LA, bif.LI);
    else n_pass++;
  endtask

  task automatic test_bad_checksum();
    set_nominal();
    do_load(2, 1'b1, 1'b0);
  endtask

  task automatic test_back_pressure();
    set_nominal();
    gap = 1'b1;
    do_load(2, 1'b0, 1'b0);
    gap = 1'b0;
  endtask

  task automatic test_count_zero();
    for (int i = 0; i < 256; i++) begin
      his[i] = {4'h0, i[7:4]};
      los[i] = {4'h0, i[3:0]};
    end
    do_load(256, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    set_nominal();
    pulse_start();
    send(8'h03);
    sb.push_back({8'h00, 8'hAB, 4'h5});
    send(8'hAB);
    send(8'hC5);
    sb.push_back({8'h01, 8'h12, 4'h6});
    send(8'h12);
    send(8'h36);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bif.LE, bif.busy, bif.cpu_en, bif.done, bif.err} !== 5'b00100)
      $display("FAIL reset_mid LE/busy/cpu_en/done/err=%b required 00100", {bif.LE, bif.busy, bif.cpu_en, bif.done, bif.err});
    else n_pass++;
    n_total++;
    if ({bif.LA, bif.LI} !== 20'h0) $display("FAIL reset_mid_regs LA/LI=%h/%h required 00/000", bif.LA, bif.LI);
    else n_pass++;
    n_total++;
    if (sb.size() != 0) $display("FAIL reset_mid_writes pending=%0d required 0", sb.size());
    else n_pass++;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (bif.busy !== 1'b0) $display("FAIL no_resume busy=%b required 0", bif.busy);
    else n_pass++;
    do_load(2, 1'b0, 1'b0);
  endtask

  task automatic test_start_busy();
    set_nominal();
    do_load(2, 1'b0, 1'b1);
  endtask

  initial begin
    bif.start = 1'b0;
    bif.byte_valid = 1'b0;
    bif.byte_data = 8'h00;
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_back_pressure();
    test_count_zero();
    test_reset_mid();
    test_start_busy();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
